cva6_clint_lite: RTL and testbench
==================================

CVA6_CLINT_LITE -- requirements
Module: cva6_clint_lite

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 100: the number of aclk cycles per mtime increment, legal range 1..65535.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16: the AXI4-Lite address width, of which only bits [15:0] are decoded.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port rtc_i, input, 1 bit: external real-time-clock tick, asynchronous; it is used only under CLINT_LITE_RTC_SYNC_EN.
REQ-006 The block SHALL have the AW channel: s_axil_awvalid in 1, s_axil_awready out 1, s_axil_awaddr in ADDR_WIDTH.
REQ-007 The block SHALL have the W channel: s_axil_wvalid in 1, s_axil_wready out 1, s_axil_wdata in 64, s_axil_wstrb in 8.
REQ-008 The block SHALL have the B channel: s_axil_bvalid out 1, s_axil_bready in 1, s_axil_bresp out 2.
REQ-009 The block SHALL have the AR and R channels: s_axil_arvalid in 1, s_axil_arready out 1, s_axil_araddr in ADDR_WIDTH, s_axil_rvalid out 1, s_axil_rready in 1, s_axil_rdata out 64, s_axil_rresp out 2.
REQ-010 The block SHALL have port ipi_o, output, 1 bit: the software interrupt, driving the core's ipi_in.
REQ-011 The block SHALL have port timer_irq_o, output, 1 bit: the machine timer interrupt, driving the core's timer_irq_i.

Function
REQ-012 The register map SHALL be: msip at 0x0000 (bit 0, all other bits read 0); mtimecmp at 0x4000 (64 bits); mtime at 0xBFF8 (64 bits).
REQ-013 The address decode SHALL compare addr[15:3] only and ignore addr[2:0].
REQ-014 Writes SHALL honour wstrb per byte; a write to msip SHALL update bit 0 only when wstrb[0]=1.
REQ-015 The write FSM SHALL have three states, W_IDLE, W_ADDR_DATA and W_RESP.
REQ-016 In W_IDLE the block SHALL assert awready and wready independently; each channel is latched on its own handshake, in either order or in the same cycle.
REQ-017 Once both AW and W are latched, the block SHALL perform the register update in that cycle and assert bvalid in the next cycle (W_RESP).
REQ-018 In W_RESP, awready and wready SHALL be 0; bvalid and bresp SHALL hold until bready, after which the FSM returns to W_IDLE.
REQ-019 The read FSM SHALL have two states, R_IDLE (arready=1) and R_DATA.
REQ-020 After an AR handshake, rvalid SHALL rise the next cycle with rdata sampled at AR acceptance; rvalid and rdata SHALL hold until rready.
REQ-021 An unmapped address SHALL return resp=2'b10 (SLVERR), rdata=0 and no state change; a mapped address SHALL return 2'b00.
REQ-022 The read and write paths SHALL be fully independent; at most one transaction of each kind is outstanding.
REQ-023 A 16-bit prescaler SHALL count 0..PRESCALE-1; at wrap, mtime increments by 1, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF wraps to 0).
REQ-024 When a software write to mtime and a tick occur in the same cycle, the written bytes SHALL win, unwritten bytes take the incremented value, and the prescaler SHALL NOT reset.
REQ-025 timer_irq_o SHALL be registered as (mtime >= mtimecmp), evaluated on the post-update values; it is therefore valid 1 cycle after any change.
REQ-026 ipi_o SHALL equal the msip register, with a 1-cycle latency from the write-commit cycle.
REQ-027 Simultaneous read and write of the same register SHALL return the pre-write value.

Reset
REQ-028 On aresetn=0 at a clock edge, the block SHALL set: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, both FSMs idle, all valid and ready outputs 0, resp=0, rdata=0, ipi_o=0, timer_irq_o=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it without producing a response; ready outputs SHALL reassert in the first cycle after release.

Configuration
REQ-030 With CLINT_LITE_RTC_SYNC_EN defined, rtc_i SHALL pass through a 2-flop synchronizer and mtime SHALL increment once per synchronized rising edge; PRESCALE and the prescaler are unused.
REQ-031 Without CLINT_LITE_RTC_SYNC_EN, rtc_i SHALL be ignored and the prescaler of REQ-023 SHALL be used.

Verification
REQ-032 The bench SHALL cover: PRESCALE=4, write mtimecmp=3 -> timer_irq_o=0 until mtime reaches 3 (about cycle 12 after reset), then 1.
REQ-033 The bench SHALL cover: W presented 3 cycles before AW to 0x0000 with wdata=1, wstrb=0x01 -> bvalid 1 cycle after AW, bresp=0, ipi_o=1 the following cycle.
REQ-034 The bench SHALL cover: read from 0x1000 -> rresp=2'b10, rdata=0; read from 0xBFF8 -> rresp=0 and current mtime.
REQ-035 The bench SHALL cover: bready held low for 5 cycles -> bvalid stable, awready=0 throughout; a second AW is accepted only after the B handshake.
REQ-036 The bench SHALL cover: write mtime=0xFFFF_FFFF_FFFF_FFFF, then one tick -> mtime=0 and timer_irq_o clears if mtimecmp is non-zero.
REQ-037 The bench SHALL cover: mtime write with wstrb=0x0F coinciding with a tick -> low word takes the written value, high word takes the incremented value.

Source files
------------

// File: rtl/cva6_clint_lite.sv
// -----------------------------------------------------------------------------
// cva6_clint_lite
// Minimal core-local interruptor for a single CVA6 hart, behind a 64-bit
// AXI4-Lite slave port.
//
// Register map (decoded on addr[15:3]; addr[2:0] ignored):
//   0x0000 msip      bit 0 only, other bits read 0
//   0x4000 mtimecmp  64 bits, resets to all ones
//   0xBFF8 mtime     64 bits, resets to 0
// Any other address: SLVERR, read data 0, no state change.
//
// Ports:
//   aclk, aresetn     single clock, synchronous active-low reset
//   rtc_i             external RTC tick (used only with CLINT_LITE_RTC_SYNC_EN)
//   s_axil_aw*/w*/b*  AXI4-Lite write address / data / response channels
//   s_axil_ar*/r*     AXI4-Lite read address / data channels
//   ipi_o             software interrupt (mirror of msip)
//   timer_irq_o       machine timer interrupt, registered mtime >= mtimecmp
//
// Build option:
//   CLINT_LITE_RTC_SYNC_EN  when defined, mtime advances once per synchronized
//                           rising edge of rtc_i instead of every PRESCALE aclk
//                           cycles.
// -----------------------------------------------------------------------------
module cva6_clint_lite #(
   parameter int unsigned PRESCALE   = 100,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  rtc_i,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   input  logic [63:0]           s_axil_wdata,
   input  logic [7:0]            s_axil_wstrb,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   output logic [1:0]            s_axil_bresp,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic [63:0]           s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  ipi_o,
   output logic                  timer_irq_o
);

   localparam logic [12:0] MSIP_IDX     = 13'h0000;
   localparam logic [12:0] MTIMECMP_IDX = 13'h0800;
   localparam logic [12:0] MTIME_IDX    = 13'h17FF;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   // ---------------------------------------------------------------- state
   w_state_t    w_state_reg, w_state_next;
   logic        aw_have_reg, aw_have_next;
   logic        w_have_reg, w_have_next;
   logic [12:0] awidx_reg, awidx_next;
   logic [63:0] wdata_reg, wdata_next;
   logic [7:0]  wstrb_reg, wstrb_next;
   logic [1:0]  bresp_reg, bresp_next;

   r_state_t    r_state_reg, r_state_next;
   logic [63:0] rdata_reg, rdata_next;
   logic [1:0]  rresp_reg, rresp_next;

   logic [63:0] mtime_reg, mtime_next, mtime_inc;
   logic [63:0] mtimecmp_reg, mtimecmp_next;
   logic        msip_reg, msip_next;
   logic        timer_irq_reg;
   logic        tick;

   // ---------------------------------------------------------------- write path
   logic        w_accepting, aw_hs, w_hs, wr_commit;
   logic [12:0] wr_idx;
   logic [63:0] wr_data;
   logic [7:0]  wr_strb;
   logic        wr_mapped;

   // Readies are gated by aresetn so they are low while reset is held and
   // come back in the very first cycle after release.
   assign w_accepting    = aresetn & (w_state_reg != W_RESP);
   assign s_axil_awready = w_accepting & ~aw_have_reg;
   assign s_axil_wready  = w_accepting & ~w_have_reg;
   assign aw_hs          = s_axil_awvalid & s_axil_awready;
   assign w_hs           = s_axil_wvalid & s_axil_wready;

   // A channel that was latched earlier is taken from its holding register,
   // otherwise straight from the bus, so the commit happens in the cycle the
   // second handshake completes.
   assign wr_idx    = aw_have_reg ? awidx_reg : s_axil_awaddr[15:3];
   assign wr_data   = w_have_reg ? wdata_reg : s_axil_wdata;
   assign wr_strb   = w_have_reg ? wstrb_reg : s_axil_wstrb;
   assign wr_mapped = (wr_idx == MSIP_IDX) | (wr_idx == MTIMECMP_IDX) | (wr_idx == MTIME_IDX);
   assign wr_commit = w_accepting & (aw_have_reg | aw_hs) & (w_have_reg | w_hs);

   always_comb begin
      w_state_next = w_state_reg;
      aw_have_next = aw_have_reg;
      w_have_next  = w_have_reg;
      awidx_next   = awidx_reg;
      wdata_next   = wdata_reg;
      wstrb_next   = wstrb_reg;
      bresp_next   = bresp_reg;
      case (w_state_reg)
         W_IDLE, W_ADDR_DATA: begin
            if (wr_commit) begin
               w_state_next = W_RESP;
               aw_have_next = 1'b0;
               w_have_next  = 1'b0;
               bresp_next   = wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else begin
               if (aw_hs) begin
                  aw_have_next = 1'b1;
                  awidx_next   = s_axil_awaddr[15:3];
               end
               if (w_hs) begin
                  w_have_next = 1'b1;
                  wdata_next  = s_axil_wdata;
                  wstrb_next  = s_axil_wstrb;
               end
               if (aw_hs | w_hs) begin
                  w_state_next = W_ADDR_DATA;
               end
            end
         end
         W_RESP: begin
            if (s_axil_bready) begin
               w_state_next = W_IDLE;
            end
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   assign s_axil_bvalid = (w_state_reg == W_RESP);
   assign s_axil_bresp  = bresp_reg;

   // ---------------------------------------------------------------- read path
   logic        ar_hs;
   logic [12:0] rd_idx;

   assign s_axil_arready = aresetn & (r_state_reg == R_IDLE);
   assign ar_hs          = s_axil_arvalid & s_axil_arready;
   assign rd_idx         = s_axil_araddr[15:3];

   // Read data comes from the registers' current values, so a write
   // committing in the same cycle is not visible to this read.
   always_comb begin
      r_state_next = r_state_reg;
      rdata_next   = rdata_reg;
      rresp_next   = rresp_reg;
      case (r_state_reg)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_next = R_DATA;
               rresp_next   = RESP_OKAY;
               case (rd_idx)
                  MSIP_IDX:     rdata_next = {63'd0, msip_reg};
                  MTIMECMP_IDX: rdata_next = mtimecmp_reg;
                  MTIME_IDX:    rdata_next = mtime_reg;
                  default: begin
                     rdata_next = 64'd0;
                     rresp_next = RESP_SLVERR;
                  end
               endcase
            end
         end
         R_DATA: begin
            if (s_axil_rready) begin
               r_state_next = R_IDLE;
            end
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   assign s_axil_rvalid = (r_state_reg == R_DATA);
   assign s_axil_rdata  = rdata_reg;
   assign s_axil_rresp  = rresp_reg;

   // ---------------------------------------------------------------- time base
`ifdef CLINT_LITE_RTC_SYNC_EN
   logic [1:0] rtc_sync_reg;
   logic       rtc_prev_reg;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rtc_sync_reg <= 2'b00;
         rtc_prev_reg <= 1'b0;
      end else begin
         rtc_sync_reg <= {rtc_sync_reg[0], rtc_i};
         rtc_prev_reg <= rtc_sync_reg[1];
      end
   end

   assign tick = rtc_sync_reg[1] & ~rtc_prev_reg;
`else
   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
   logic [15:0] presc_reg, presc_next;
   logic        unused_rtc;

   assign unused_rtc = rtc_i;
   assign tick       = (presc_reg == PRESC_MAX);
   assign presc_next = tick ? 16'd0 : presc_reg + 16'd1;

   // The prescaler free-runs; software writes to mtime never disturb it.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         presc_reg <= 16'd0;
      end else begin
         presc_reg <= presc_next;
      end
   end
`endif

   // ---------------------------------------------------------------- registers
   assign mtime_inc = mtime_reg + {63'd0, tick};

   // Per-byte merge: strobed bytes of a committing write win over the
   // incremented timer value, unstrobed bytes keep the incremented value.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_byte
         logic mtime_we, mtimecmp_we;
         assign mtime_we    = wr_commit & (wr_idx == MTIME_IDX) & wr_strb[gi];
         assign mtimecmp_we = wr_commit & (wr_idx == MTIMECMP_IDX) & wr_strb[gi];
         assign mtime_next[gi*8 +: 8]    = mtime_we ? wr_data[gi*8 +: 8] : mtime_inc[gi*8 +: 8];
         assign mtimecmp_next[gi*8 +: 8] = mtimecmp_we ? wr_data[gi*8 +: 8] : mtimecmp_reg[gi*8 +: 8];
      end
   endgenerate

   assign msip_next = (wr_commit & (wr_idx == MSIP_IDX) & wr_strb[0]) ? wr_data[0] : msip_reg;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         w_state_reg   <= W_IDLE;
         aw_have_reg   <= 1'b0;
         w_have_reg    <= 1'b0;
         awidx_reg     <= 13'd0;
         wdata_reg     <= 64'd0;
         wstrb_reg     <= 8'd0;
         bresp_reg     <= RESP_OKAY;
         r_state_reg   <= R_IDLE;
         rdata_reg     <= 64'd0;
         rresp_reg     <= RESP_OKAY;
         mtime_reg     <= 64'd0;
         mtimecmp_reg  <= '1;
         msip_reg      <= 1'b0;
         timer_irq_reg <= 1'b0;
      end else begin
         w_state_reg   <= w_state_next;
         aw_have_reg   <= aw_have_next;
         w_have_reg    <= w_have_next;
         awidx_reg     <= awidx_next;
         wdata_reg     <= wdata_next;
         wstrb_reg     <= wstrb_next;
         bresp_reg     <= bresp_next;
         r_state_reg   <= r_state_next;
         rdata_reg     <= rdata_next;
         rresp_reg     <= rresp_next;
         mtime_reg     <= mtime_next;
         mtimecmp_reg  <= mtimecmp_next;
         msip_reg      <= msip_next;
         // Compare the values being loaded so the interrupt tracks the
         // registers with no extra lag.
         timer_irq_reg <= (mtime_next >= mtimecmp_next);
      end
   end

   assign ipi_o       = msip_reg;
   assign timer_irq_o = timer_irq_reg;

   // ---------------------------------------------------------------- unused
   logic unused_addr_lo;
   assign unused_addr_lo = ^{s_axil_awaddr[2:0], s_axil_araddr[2:0]};

   generate
      if (ADDR_WIDTH > 16) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^{s_axil_awaddr[ADDR_WIDTH-1:16], s_axil_araddr[ADDR_WIDTH-1:16]};
      end
   endgenerate

endmodule

// File: tb/tb_cva6_clint_lite.sv
`timescale 1ns/1ps
module tb_cva6_clint_lite;

   localparam int PRESCALE_TB = 4;
   localparam int AW          = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          rtc_i = 1'b0;
   logic          s_axil_awvalid = 1'b0;
   logic          s_axil_awready;
   logic [AW-1:0] s_axil_awaddr = '0;
   logic          s_axil_wvalid = 1'b0;
   logic          s_axil_wready;
   logic [63:0]   s_axil_wdata = '0;
   logic [7:0]    s_axil_wstrb = '0;
   logic          s_axil_bvalid;
   logic          s_axil_bready = 1'b0;
   logic [1:0]    s_axil_bresp;
   logic          s_axil_arvalid = 1'b0;
   logic          s_axil_arready;
   logic [AW-1:0] s_axil_araddr = '0;
   logic          s_axil_rvalid;
   logic          s_axil_rready = 1'b0;
   logic [63:0]   s_axil_rdata;
   logic [1:0]    s_axil_rresp;
   logic          ipi_o;
   logic          timer_irq_o;

   int checks;
   int failures;

   cva6_clint_lite #(.PRESCALE(PRESCALE_TB), .ADDR_WIDTH(AW)) dut (
      .aclk(aclk), .aresetn(aresetn), .rtc_i(rtc_i),
      .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
      .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_araddr(s_axil_araddr),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .ipi_o(ipi_o), .timer_irq_o(timer_irq_o)
   );

   always #5 aclk = ~aclk;

   // ---------------------------------------------------------------- reference model
   // Time is derived from the count of clock edges since reset release;
   // write tasks post a request that lands on the edge where the write commits.
   int          cyc_m;
   logic [63:0] mtime_m, cmp_m;
   logic        msip_m, irq_m;
   int          wr_req_cnt, wr_done_cnt;
   logic [15:0] mw_addr;
   logic [63:0] mw_data;
   logic [7:0]  mw_strb;

   function automatic bit is_mapped(input logic [15:0] a);
      return (a & 16'hFFF8) inside {16'h0000, 16'h4000, 16'hBFF8};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] base, input logic [63:0] data,
                                         input logic [7:0] strb);
      logic [63:0] mask = '0;
      for (int i = 0; i < 8; i++) if (strb[i]) mask[i*8 +: 8] = 8'hFF;
      return (data & mask) | (base & ~mask);
   endfunction

   function automatic bit m_wr_to(input logic [15:0] reg_addr);
      return (wr_req_cnt != wr_done_cnt) && ((mw_addr & 16'hFFF8) == reg_addr);
   endfunction

   function automatic logic [63:0] f_mtime();
      logic [63:0] t = mtime_m + (((cyc_m % PRESCALE_TB) == PRESCALE_TB - 1) ? 64'd1 : 64'd0);
      return m_wr_to(16'hBFF8) ? merge(t, mw_data, mw_strb) : t;
   endfunction

   function automatic logic [63:0] f_cmp();
      return m_wr_to(16'h4000) ? merge(cmp_m, mw_data, mw_strb) : cmp_m;
   endfunction

   function automatic logic f_msip();
      return (m_wr_to(16'h0000) && mw_strb[0]) ? mw_data[0] : msip_m;
   endfunction

   always @(posedge aclk) begin
      if (!aresetn) begin
         cyc_m       <= 0;
         mtime_m     <= 64'd0;
         cmp_m       <= '1;
         msip_m      <= 1'b0;
         irq_m       <= 1'b0;
         wr_done_cnt <= wr_req_cnt;
      end else begin
         mtime_m     <= f_mtime();
         cmp_m       <= f_cmp();
         msip_m      <= f_msip();
         irq_m       <= (f_mtime() >= f_cmp());
         cyc_m       <= cyc_m + 1;
         wr_done_cnt <= wr_req_cnt;
      end
   end

   task automatic model_rd(input logic [15:0] a, output logic [63:0] d, output logic [1:0] r);
      r = 2'b00;
      case (a & 16'hFFF8)
         16'h0000: d = {63'd0, msip_m};
         16'h4000: d = cmp_m;
         16'hBFF8: d = mtime_m;
         default: begin d = 64'd0; r = 2'b10; end
      endcase
   endtask

   // ---------------------------------------------------------------- bus tasks
   task automatic do_write(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int c = 0;
      logic [1:0] er = is_mapped(addr) ? 2'b00 : 2'b10;
      while (!(aw_done && w_done) && c < 40) begin
         @(negedge aclk);
         s_axil_awaddr  = addr;
         s_axil_wdata   = data;
         s_axil_wstrb   = strb;
         s_axil_awvalid = !aw_done && (c >= aw_dly);
         s_axil_wvalid  = !w_done && (c >= w_dly);
         #1;
         aw_hs = s_axil_awvalid && s_axil_awready;
         w_hs  = s_axil_wvalid && s_axil_wready;
         if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            mw_addr = addr; mw_data = data; mw_strb = strb;
            wr_req_cnt++;
         end
         @(posedge aclk);
         aw_done = aw_done || aw_hs;
         w_done  = w_done || w_hs;
         c++;
      end
      #1;
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      checks++;
      if (!(aw_done && w_done)) begin
         failures++;
         $display("FAIL wr_handshake addr=%h: aw_done=%0d w_done=%0d required both 1", addr, aw_done, w_done);
         return;
      end
      @(negedge aclk);
      checks += 3;
      if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== er) begin
         failures++;
         $display("FAIL wr_bvalid addr=%h: bvalid=%b bresp=%b required 1/%b", addr, s_axil_bvalid, s_axil_bresp, er);
      end
      if (ipi_o !== msip_m) begin
         failures++;
         $display("FAIL wr_ipi addr=%h: ipi_o=%b required %b", addr, ipi_o, msip_m);
      end
      if (timer_irq_o !== irq_m) begin
         failures++;
         $display("FAIL wr_irq addr=%h: timer_irq_o=%b required %b", addr, timer_irq_o, irq_m);
      end
      for (int i = 0; i < b_dly; i++) begin
         @(negedge aclk);
         checks++;
         if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== er || s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0) begin
            failures++;
            $display("FAIL wr_bhold cyc=%0d: bvalid=%b bresp=%b awready=%b wready=%b required 1/%b/0/0",
                     i, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready, er);
         end
      end
      s_axil_bready = 1'b1;
      @(posedge aclk);
      #1;
      s_axil_bready = 1'b0;
      checks++;
      if (s_axil_bvalid !== 1'b0) begin
         failures++;
         $display("FAIL wr_bdone addr=%h: bvalid=%b required 0", addr, s_axil_bvalid);
      end
      $display("WR addr=%h data=%h strb=%h bresp=%b", addr, data, strb, er);
   endtask

   task automatic do_read(input logic [15:0] addr, input int r_dly, output logic [63:0] rd);
      logic [63:0] ed;
      logic [1:0]  er;
      int k = 0;
      rd = '0;
      @(negedge aclk);
      s_axil_arvalid = 1'b1;
      s_axil_araddr  = addr;
      #1;
      while (!s_axil_arready && k < 20) begin
         @(negedge aclk);
         #1;
         k++;
      end
      checks++;
      if (!s_axil_arready) begin
         failures++;
         $display("FAIL rd_arready addr=%h: arready=%b required 1", addr, s_axil_arready);
         s_axil_arvalid = 1'b0;
         return;
      end
      model_rd(addr, ed, er);
      @(posedge aclk);
      #1;
      s_axil_arvalid = 1'b0;
      for (int i = 0; i <= r_dly; i++) begin
         @(negedge aclk);
         checks++;
         if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== ed || s_axil_rresp !== er) begin
            failures++;
            $display("FAIL rd_data addr=%h cyc=%0d: rvalid=%b rdata=%h rresp=%b required 1/%h/%b",
                     addr, i, s_axil_rvalid, s_axil_rdata, s_axil_rresp, ed, er);
         end
      end
      rd = s_axil_rdata;
      s_axil_rready = 1'b1;
      @(posedge aclk);
      #1;
      s_axil_rready = 1'b0;
      checks++;
      if (s_axil_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rd_done addr=%h: rvalid=%b required 0", addr, s_axil_rvalid);
      end
      $display("RD addr=%h rdata=%h rresp=%b", addr, rd, er);
   endtask

   // Return at a negedge where the model cycle count has phase ph.
   task automatic sync_phase(input int ph);
      int k = 0;
      do begin
         @(negedge aclk);
         k++;
      end while ((cyc_m % PRESCALE_TB) != ph && k < 16);
   endtask

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      aresetn = 1'b0;
      repeat (4) @(negedge aclk);
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
           s_axil_bresp, s_axil_rresp, ipi_o, timer_irq_o} !== 11'd0 || s_axil_rdata !== 64'd0) begin
         failures++;
         $display("FAIL reset_outputs: aw/w/ar_ready=%b%b%b b/rvalid=%b%b resp=%b/%b ipi=%b irq=%b rdata=%h required all 0",
                  s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
                  s_axil_bresp, s_axil_rresp, ipi_o, timer_irq_o, s_axil_rdata);
      end
      aresetn = 1'b1;
      #1;
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_release_ready: aw/w/ar_ready=%b%b%b required 111",
                  s_axil_awready, s_axil_wready, s_axil_arready);
      end
      $display("RESET released");
   endtask

   task automatic test_timer_irq();
      int rise_cyc = -1;
      do_write(16'h4000, 64'd3, 8'hFF, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge aclk);
         checks++;
         if (timer_irq_o !== irq_m) begin
            failures++;
            $display("FAIL timer_irq cyc=%0d: timer_irq_o=%b required %b (mtime=%0d)", cyc_m, timer_irq_o, irq_m, mtime_m);
         end
         if (timer_irq_o === 1'b1 && rise_cyc < 0) rise_cyc = cyc_m;
      end
      checks++;
      if (timer_irq_o !== 1'b1) begin
         failures++;
         $display("FAIL timer_irq_final: timer_irq_o=%b required 1", timer_irq_o);
      end
      $display("TIMER irq rose at cycle %0d after reset", rise_cyc);
   endtask

   task automatic test_w_before_aw();
      do_write(16'h0000, 64'd1, 8'h01, 3, 0, 0);
      checks++;
      if (ipi_o !== 1'b1) begin
         failures++;
         $display("FAIL ipi_set: ipi_o=%b required 1", ipi_o);
      end
   endtask

   task automatic test_read_map();
      logic [63:0] rd;
      do_read(16'h1000, 0, rd);
      do_read(16'hBFF8, 2, rd);
      do_read(16'h4005, 1, rd);
      do_read(16'h0007, 0, rd);
   endtask

   task automatic test_b_backpressure();
      do_write(16'h4000, 64'd16, 8'hFF, 0, 0, 5);
      checks++;
      if (s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready: awready=%b wready=%b required 1/1", s_axil_awready, s_axil_wready);
      end
      do_write(16'h4000, 64'd3, 8'hFF, 0, 1, 0);
   endtask

   task automatic test_mtime_wrap();
      logic [63:0] rd;
      int k = 0;
      do_write(16'hBFF8, '1, 8'hFF, 0, 0, 0);
      while (mtime_m != 64'd0 && k < 10) begin
         @(negedge aclk);
         checks++;
         if (timer_irq_o !== irq_m) begin
            failures++;
            $display("FAIL wrap_irq cyc=%0d: timer_irq_o=%b required %b", cyc_m, timer_irq_o, irq_m);
         end
         k++;
      end
      checks++;
      if (timer_irq_o !== 1'b0) begin
         failures++;
         $display("FAIL wrap_irq_clear: timer_irq_o=%b required 0", timer_irq_o);
      end
      do_read(16'hBFF8, 0, rd);
   endtask

   task automatic test_partial_tick();
      logic [63:0] rd;
      sync_phase(PRESCALE_TB - 1);
      do_write(16'hBFF8, 64'h0000_0007_FFFF_FFFF, 8'hFF, 0, 0, 0);
      sync_phase(PRESCALE_TB - 2);
      do_write(16'hBFF8, 64'hAAAA_AAAA_1234_5678, 8'h0F, 0, 0, 0);
      do_read(16'hBFF8, 0, rd);
      checks++;
      if (rd !== 64'h0000_0008_1234_5678) begin
         failures++;
         $display("FAIL partial_tick: mtime=%h required %h", rd, 64'h0000_0008_1234_5678);
      end
   endtask

   task automatic test_rw_collision();
      logic [63:0] rd;
      do_write(16'h0000, 64'd0, 8'h01, 0, 0, 0);
      fork
         do_write(16'h0000, 64'd1, 8'h01, 0, 0, 0);
         do_read(16'h0000, 0, rd);
      join
      checks++;
      if (rd !== 64'd0) begin
         failures++;
         $display("FAIL rw_collision: rdata=%h required 0", rd);
      end
   endtask

   task automatic test_random();
      logic [63:0] rd;
      logic [15:0] a;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0: a = 16'h0000;
            1: a = 16'h4000;
            2: a = 16'hBFF8;
            default: a = 16'h1000 | 16'($urandom_range(0, 16'h0FFF));
         endcase
         a = a | 16'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0)
            do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         else
            do_read(a, $urandom_range(0, 2), rd);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge aclk);
      s_axil_awvalid = 1'b1;
      s_axil_awaddr  = 16'h0000;
      s_axil_arvalid = 1'b1;
      s_axil_araddr  = 16'hBFF8;
      @(posedge aclk);
      #1;
      s_axil_awvalid = 1'b0;
      s_axil_arvalid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      checks++;
      if (s_axil_bvalid !== 1'b0 || s_axil_rvalid !== 1'b0 || s_axil_awready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: bvalid=%b rvalid=%b awready=%b required 0/0/0",
                  s_axil_bvalid, s_axil_rvalid, s_axil_awready);
      end
      aresetn = 1'b1;
      #1;
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
         failures++;
         $display("FAIL mid_reset_ready: aw/w/ar_ready=%b%b%b required 111",
                  s_axil_awready, s_axil_wready, s_axil_arready);
      end
      @(negedge aclk);
      s_axil_wvalid = 1'b1;
      s_axil_wdata  = 64'd1;
      s_axil_wstrb  = 8'h01;
      @(posedge aclk);
      #1;
      s_axil_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         checks++;
         if (s_axil_bvalid !== 1'b0 || ipi_o !== msip_m) begin
            failures++;
            $display("FAIL mid_reset_abandon cyc=%0d: bvalid=%b ipi_o=%b required 0/%b", i, s_axil_bvalid, ipi_o, msip_m);
         end
      end
      $display("RESET mid-transaction abandoned");
   endtask

   initial begin
      test_reset();
      test_timer_irq();
      test_w_before_aw();
      test_read_map();
      test_b_backpressure();
      test_mtime_wrap();
      test_partial_tick();
      test_rw_collision();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
